// File: rtl/viterbi_acs_if.sv
// ============================================================================
//  Module      : viterbi_acs_if
//  Description : Symbol-in / decision-out bundle for the Viterbi ACS bank.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface viterbi_acs_if #(
    parameter int K      = 7,
    parameter int PM_W   = 7,
    parameter int SOFT_W = 1
);
    logic                    start;
    logic                    in_valid;
    logic [SOFT_W-1:0]       in_a0;
    logic [SOFT_W-1:0]       in_a1;
    logic [1:0]              in_erase;
    logic                    out_valid;
    logic [(1<<(K-1))-1:0]   dec_bits;
    logic [K-2:0]            best_state;
    logic [PM_W-1:0]         best_metric;
    logic                    norm_event;

    modport master (
        output start, in_valid, in_a0, in_a1, in_erase,
        input  out_valid, dec_bits, best_state, best_metric, norm_event
    );

    modport slave (
        input  start, in_valid, in_a0, in_a1, in_erase,
        output out_valid, dec_bits, best_state, best_metric, norm_event
    );
endinterface

`default_nettype wire

// File: rtl/viterbi_acs_bank.sv
// ============================================================================
//  Module      : viterbi_acs_bank
//  Description : Add-compare-select bank with saturating, normalised metrics.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module viterbi_acs_bank #(
    parameter int           K      = 7,
    parameter int           PM_W   = 7,
    parameter int           SOFT_W = 1,
    parameter logic [K-1:0] G0     = 7'o133,
    parameter logic [K-1:0] G1     = 7'o171
) (
    input  logic           clk,
    input  logic           rst,
    viterbi_acs_if.slave   acs
);

    localparam int              c_NS      = 1 << (K - 1);
    localparam logic [PM_W-1:0] c_PM_HALF = {1'b1, {(PM_W-1){1'b0}}};
    localparam logic [PM_W-1:0] c_PM_MAX  = '1;

    logic [PM_W-1:0] r_pm   [c_NS];
    logic [PM_W-1:0] w_init [c_NS];
    logic [PM_W-1:0] w_base [c_NS];
    logic [PM_W-1:0] w_raw  [c_NS];
    logic [PM_W-1:0] w_new  [c_NS];
    logic [c_NS-1:0] w_dec;
    logic [c_NS-1:0] w_msb;
    logic            w_norm;
    logic [K-2:0]    w_best_state;
    logic [PM_W-1:0] w_best_metric;

    logic            r_out_valid;
    logic [c_NS-1:0] r_dec_bits;
    logic [K-2:0]    r_best_state;
    logic [PM_W-1:0] r_best_metric;
    logic            r_norm_event;

    // Distance of one received bit from the expected bit; (2^SOFT_W-1)-r == ~r.
    function automatic logic [SOFT_W:0] bit_metric(input logic expect_one,
                                                   input logic [SOFT_W-1:0] r,
                                                   input logic erased);
        if (erased) return '0;
        return expect_one ? {1'b0, ~r} : {1'b0, r};
    endfunction

    // A start coinciding with a symbol makes the symbol see the fresh metrics.
    for (genvar s = 0; s < c_NS; s++) begin : g_init
        localparam logic [PM_W-1:0] c_INIT = (s == 0) ? '0 : c_PM_HALF;
        assign w_init[s] = c_INIT;
        assign w_base[s] = acs.start ? w_init[s] : r_pm[s];
    end

    for (genvar ns = 0; ns < c_NS; ns++) begin : g_node
        localparam int          c_P0 = (ns * 2) % c_NS;
        localparam int          c_P1 = c_P0 + 1;
        localparam int          c_U  = ns >> (K - 2);
        localparam logic [K-1:0] c_R0 = K'(c_U * c_NS + c_P0);
        localparam logic [K-1:0] c_R1 = K'(c_U * c_NS + c_P1);
        localparam logic c_E0_X0 = ^(G0 & c_R0);
        localparam logic c_E1_X0 = ^(G1 & c_R0);
        localparam logic c_E0_X1 = ^(G0 & c_R1);
        localparam logic c_E1_X1 = ^(G1 & c_R1);

        logic [SOFT_W:0] w_bm0;
        logic [SOFT_W:0] w_bm1;
        logic [PM_W:0]   w_sum0;
        logic [PM_W:0]   w_sum1;
        logic [PM_W-1:0] w_cand0;
        logic [PM_W-1:0] w_cand1;
        logic            w_sel1;

        assign w_bm0 = bit_metric(c_E0_X0, acs.in_a0, acs.in_erase[0])
                     + bit_metric(c_E1_X0, acs.in_a1, acs.in_erase[1]);
        assign w_bm1 = bit_metric(c_E0_X1, acs.in_a0, acs.in_erase[0])
                     + bit_metric(c_E1_X1, acs.in_a1, acs.in_erase[1]);

        // One extra bit catches the carry so the sum clamps instead of wrapping.
        assign w_sum0  = {1'b0, w_base[c_P0]} + (PM_W+1)'(w_bm0);
        assign w_sum1  = {1'b0, w_base[c_P1]} + (PM_W+1)'(w_bm1);
        assign w_cand0 = w_sum0[PM_W] ? c_PM_MAX : w_sum0[PM_W-1:0];
        assign w_cand1 = w_sum1[PM_W] ? c_PM_MAX : w_sum1[PM_W-1:0];

        assign w_sel1     = (w_cand1 < w_cand0);
        assign w_dec[ns]  = w_sel1;
        assign w_raw[ns]  = w_sel1 ? w_cand1 : w_cand0;
        assign w_msb[ns]  = w_raw[ns][PM_W-1];
        assign w_new[ns]  = w_norm ? {1'b0, w_raw[ns][PM_W-2:0]} : w_raw[ns];
    end

    assign w_norm = &w_msb;

    always_comb begin
        w_best_state  = '0;
        w_best_metric = w_new[0];
        for (int i = 1; i < c_NS; i++) begin
            if (w_new[i] < w_best_metric) begin
                w_best_metric = w_new[i];
                w_best_state  = (K-1)'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pm          <= w_init;
            r_out_valid   <= 1'b0;
            r_dec_bits    <= '0;
            r_best_state  <= '0;
            r_best_metric <= '0;
            r_norm_event  <= 1'b0;
        end else if (acs.in_valid) begin
            r_pm          <= w_new;
            r_out_valid   <= 1'b1;
            r_dec_bits    <= w_dec;
            r_best_state  <= w_best_state;
            r_best_metric <= w_best_metric;
            r_norm_event  <= w_norm;
        end else begin
            if (acs.start) begin
                r_pm <= w_init;
            end
            r_out_valid  <= 1'b0;
            r_norm_event <= 1'b0;
        end
    end

    assign acs.out_valid   = r_out_valid;
    assign acs.dec_bits    = r_dec_bits;
    assign acs.best_state  = r_best_state;
    assign acs.best_metric = r_best_metric;
    assign acs.norm_event  = r_norm_event;

endmodule

`default_nettype wire

// File: tb/tb_viterbi_acs_bank.sv
// ============================================================================
//  Module      : tb_viterbi_acs_bank
//  Description : Self-checking bench for three ACS bank configurations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_viterbi_acs_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    viterbi_acs_if #(.K(7), .PM_W(7), .SOFT_W(1)) bus_a ();
    viterbi_acs_if #(.K(7), .PM_W(4), .SOFT_W(1)) bus_b ();
    viterbi_acs_if #(.K(5), .PM_W(6), .SOFT_W(3)) bus_c ();

    viterbi_acs_bank #(.K(7), .PM_W(7), .SOFT_W(1), .G0(7'o133), .G1(7'o171))
        dut_a (.clk(clk), .rst(rst), .acs(bus_a));
    viterbi_acs_bank #(.K(7), .PM_W(4), .SOFT_W(1), .G0(7'o133), .G1(7'o171))
        dut_b (.clk(clk), .rst(rst), .acs(bus_b));
    viterbi_acs_bank #(.K(5), .PM_W(6), .SOFT_W(3), .G0(5'o23), .G1(5'o35))
        dut_c (.clk(clk), .rst(rst), .acs(bus_c));

    int checks = 0;
    int errors = 0;

    // Reference model: plain integer trellis arithmetic per configuration.
    int cfg_k   [3] = '{7, 7, 5};
    int cfg_pmw [3] = '{7, 4, 6};
    int cfg_sw  [3] = '{1, 1, 3};
    int cfg_g0  [3] = '{'o133, 'o133, 'o23};
    int cfg_g1  [3] = '{'o171, 'o171, 'o35};
    int          m_pm [3][64];
    int          e_ov [3];
    int          e_bs [3];
    int          e_bm [3];
    int          e_norm [3];
    logic [63:0] e_dec [3];

    typedef struct {
        bit       r, st, v;
        int       s0, s1;
        bit [1:0] er;
        int       x_ov, x_bs, x_bm, x_norm, x_d0;
        longint   x_dec;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int id, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0d expected %0d", name, id, act, exp);
        end
    endtask

    task automatic model_init(input int id);
        int nsn = 1 << (cfg_k[id] - 1);
        int half = 1 << (cfg_pmw[id] - 1);
        for (int s = 0; s < nsn; s++) m_pm[id][s] = (s == 0) ? 0 : half;
    endtask

    task automatic model_step(input int id, input bit r, input bit st, input bit v,
                              input int a0, input int a1, input bit [1:0] er);
        int nsn, half, pmax, rmax, u, p, w, d0, d1, allhi;
        int c [2];
        int np [64];
        nsn  = 1 << (cfg_k[id] - 1);
        half = 1 << (cfg_pmw[id] - 1);
        pmax = (1 << cfg_pmw[id]) - 1;
        rmax = (1 << cfg_sw[id]) - 1;
        if (r) begin
            model_init(id);
            e_ov[id] = 0; e_dec[id] = 0; e_bs[id] = 0; e_bm[id] = 0; e_norm[id] = 0;
            return;
        end
        if (st) model_init(id);
        if (!v) begin
            e_ov[id] = 0; e_norm[id] = 0;
            return;
        end
        e_dec[id] = 0;
        for (int ns = 0; ns < nsn; ns++) begin
            u = ns / (nsn / 2);
            for (int x = 0; x < 2; x++) begin
                p  = ((ns * 2) % nsn) + x;
                w  = u * nsn + p;
                d0 = er[0] ? 0 : (($countones(cfg_g0[id] & w) % 2) != 0 ? rmax - a0 : a0);
                d1 = er[1] ? 0 : (($countones(cfg_g1[id] & w) % 2) != 0 ? rmax - a1 : a1);
                c[x] = m_pm[id][p] + d0 + d1;
                if (c[x] > pmax) c[x] = pmax;
            end
            if (c[1] < c[0]) begin
                np[ns] = c[1];
                e_dec[id][ns] = 1'b1;
            end else begin
                np[ns] = c[0];
            end
        end
        allhi = 1;
        for (int s = 0; s < nsn; s++) if (np[s] < half) allhi = 0;
        e_bm[id] = pmax + 1;
        for (int s = 0; s < nsn; s++) begin
            if (allhi != 0) np[s] -= half;
            m_pm[id][s] = np[s];
            if (np[s] < e_bm[id]) begin
                e_bm[id] = np[s];
                e_bs[id] = s;
            end
        end
        e_ov[id] = 1; e_norm[id] = allhi;
    endtask

    task automatic compare_all();
        chk("out_valid",   0, bus_a.out_valid,        e_ov[0]);
        chk("dec_bits",    0, 64'(bus_a.dec_bits),    e_dec[0]);
        chk("best_state",  0, bus_a.best_state,       e_bs[0]);
        chk("best_metric", 0, bus_a.best_metric,      e_bm[0]);
        chk("norm_event",  0, bus_a.norm_event,       e_norm[0]);
        chk("out_valid",   1, bus_b.out_valid,        e_ov[1]);
        chk("dec_bits",    1, 64'(bus_b.dec_bits),    e_dec[1]);
        chk("best_state",  1, bus_b.best_state,       e_bs[1]);
        chk("best_metric", 1, bus_b.best_metric,      e_bm[1]);
        chk("norm_event",  1, bus_b.norm_event,       e_norm[1]);
        chk("out_valid",   2, bus_c.out_valid,        e_ov[2]);
        chk("dec_bits",    2, 64'(bus_c.dec_bits),    e_dec[2]);
        chk("best_state",  2, bus_c.best_state,       e_bs[2]);
        chk("best_metric", 2, bus_c.best_metric,      e_bm[2]);
        chk("norm_event",  2, bus_c.norm_event,       e_norm[2]);
    endtask

    // s0/s1 are 3-bit soft values; the hard instances see their MSB.
    task automatic cycle(input bit r, input bit st, input bit v,
                         input int s0, input int s1, input bit [1:0] er);
        @(negedge clk);
        rst = r;
        bus_a.start = st; bus_a.in_valid = v; bus_a.in_erase = er;
        bus_a.in_a0 = 1'(s0 >> 2); bus_a.in_a1 = 1'(s1 >> 2);
        bus_b.start = st; bus_b.in_valid = v; bus_b.in_erase = er;
        bus_b.in_a0 = 1'(s0 >> 2); bus_b.in_a1 = 1'(s1 >> 2);
        bus_c.start = st; bus_c.in_valid = v; bus_c.in_erase = er;
        bus_c.in_a0 = 3'(s0); bus_c.in_a1 = 3'(s1);
        model_step(0, r, st, v, s0 >> 2, s1 >> 2, er);
        model_step(1, r, st, v, s0 >> 2, s1 >> 2, er);
        model_step(2, r, st, v, s0, s1, er);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    function automatic void add(input bit r, input bit st, input bit v, input int s0,
                                input int s1, input bit [1:0] er, input int x_ov,
                                input int x_bs, input int x_bm, input int x_norm,
                                input int x_d0, input longint x_dec);
        vec_t t;
        t.r = r; t.st = st; t.v = v; t.s0 = s0; t.s1 = s1; t.er = er;
        t.x_ov = x_ov; t.x_bs = x_bs; t.x_bm = x_bm; t.x_norm = x_norm;
        t.x_d0 = x_d0; t.x_dec = x_dec;
        tbl.push_back(t);
    endfunction

    function automatic int par(input int v);
        return $countones(v) % 2;
    endfunction

    initial begin
        int          enc, w, b0, b1, st_tb, x;
        logic [63:0] dec_hist [8];
        bit          ubits [8] = '{1, 0, 1, 1, 0, 0, 0, 0};
        int          enc_st [8];
        bit          decoded [8];

        bus_a.start = 0; bus_a.in_valid = 0; bus_a.in_a0 = 0; bus_a.in_a1 = 0; bus_a.in_erase = 0;
        bus_b.start = 0; bus_b.in_valid = 0; bus_b.in_a0 = 0; bus_b.in_a1 = 0; bus_b.in_erase = 0;
        bus_c.start = 0; bus_c.in_valid = 0; bus_c.in_a0 = 0; bus_c.in_a1 = 0; bus_c.in_erase = 0;

        // -1 marks a field the table leaves to the reference model.
        add(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) add(0, 0, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, -1);
        add(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 1, 7, 7, 2'b11, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 1, 7, 7, 2'b00, 1, -1, -1, -1, -1, -1);
        add(0, 1, 1, 0, 0, 2'b00, 1, 0, 0, 0, -1, -1);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 7, 0, 2'b00, 1, -1, -1, -1, -1, -1);
        add(0, 1, 0, 0, 0, 2'b00, 0, -1, -1, 0, -1, -1);
        add(0, 0, 1, 7, 7, 2'b00, 1, -1, -1, -1, -1, -1);
        add(1, 0, 1, 7, 7, 2'b00, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, -1);

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].st, tbl[i].v, tbl[i].s0, tbl[i].s1, tbl[i].er);
            if (tbl[i].x_ov >= 0)   chk("tbl_out_valid",   0, bus_a.out_valid,   tbl[i].x_ov);
            if (tbl[i].x_bs >= 0)   chk("tbl_best_state",  0, bus_a.best_state,  tbl[i].x_bs);
            if (tbl[i].x_bm >= 0)   chk("tbl_best_metric", 0, bus_a.best_metric, tbl[i].x_bm);
            if (tbl[i].x_norm >= 0) chk("tbl_norm_event",  0, bus_a.norm_event,  tbl[i].x_norm);
            if (tbl[i].x_d0 >= 0)   chk("tbl_dec_bit0",    0, bus_a.dec_bits[0], tbl[i].x_d0);
            if (tbl[i].x_dec >= 0)  chk("tbl_dec_bits",    0, 64'(bus_a.dec_bits), tbl[i].x_dec);
        end

        // Encoded stream with a0 of the third symbol flipped, then traceback.
        cycle(1, 0, 0, 0, 0, 2'b00);
        enc = 0;
        for (int i = 0; i < 8; i++) begin
            w  = (int'(ubits[i]) << 6) | enc;
            b0 = par('o133 & w);
            b1 = par('o171 & w);
            if (i == 2) b0 = 1 - b0;
            enc = w >> 1;
            enc_st[i] = enc;
            cycle(0, 0, 1, b0 * 7, b1 * 7, 2'b00);
            dec_hist[i] = 64'(bus_a.dec_bits);
            chk("enc_best_metric", 0, bus_a.best_metric, (i < 2) ? 0 : 1);
            if (i != 2) chk("enc_best_state", 0, bus_a.best_state, enc_st[i]);
        end
        st_tb = enc_st[7];
        for (int i = 7; i >= 0; i--) begin
            decoded[i] = st_tb[5];
            x = int'(dec_hist[i][st_tb]);
            st_tb = ((st_tb << 1) & 63) | x;
        end
        for (int i = 0; i < 8; i++) chk("traceback_bit", 0, decoded[i], ubits[i]);

        // Continuous a=11 on all configurations; the 4-bit one must normalise.
        cycle(1, 0, 0, 0, 0, 2'b00);
        for (int i = 0; i < 64; i++) begin
            cycle(0, 0, 1, 7, 7, 2'b00);
            if (bus_b.norm_event) chk("norm_bm_le7", 1, int'(bus_b.best_metric <= 7), 1);
        end

        // Randomised traffic including erasures, starts, gaps and resets.
        for (int i = 0; i < 600; i++) begin
            bit       r, st, v;
            bit [1:0] er;
            r  = ($urandom_range(0, 99) == 0);
            st = ($urandom_range(0, 24) == 0);
            v  = ($urandom_range(0, 9) != 0);
            er = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            cycle(r, st, v, $urandom_range(0, 7), $urandom_range(0, 7), er);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/viterbi_acs_bank.md
Name: viterbi_acs_bank

Overview:
- Parametrised add-compare-select (ACS) bank for the 802.11a Viterbi decoder. Successor to the per-branch saturating error adder.
- Holds registered path metrics for all 2^(K-1) trellis states.
- Computes hard- or soft-decision branch metrics with per-bit erasure for depunctured rates, and saturates and normalises metrics.
- Emits one survivor-decision vector per input symbol to the traceback unit.

Parameters:
- K, 7, constraint length; NS = 2^(K-1) states.
- PM_W, 7, path-metric width in bits.
- SOFT_W, 1, bits per received code bit (1 = hard decision).
- G0, 7'o133, generator polynomial for code bit a0; MSB taps the newest input bit.
- G1, 7'o171, generator polynomial for code bit a1.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, frame start; re-initialises the path metrics.
- in_valid, input, 1, received symbol present this cycle.
- in_a0, input, SOFT_W, received code bit 0 (0 = strongest '0', all-ones = strongest '1').
- in_a1, input, SOFT_W, received code bit 1.
- in_erase, input, 2, per-bit erasure flags ([0] = a0, [1] = a1).
- out_valid, output, 1, decisions/best_* valid.
- dec_bits, output, NS, survivor decision per state.
- best_state, output, K-1, index of the minimum-metric state.
- best_metric, output, PM_W, value of the minimum metric.
- norm_event, output, 1, normalisation applied on this update.

Behaviour:
- Reset (synchronous, highest priority):
  - PM[0]=0; PM[s≠0]=2^(PM_W-1).
  - out_valid=0, dec_bits=0, best_state=0, best_metric=0, norm_event=0.
- start (without rst): same metric initialisation as reset, effective next edge.
  - start with in_valid in the same cycle: the symbol is processed from the initialised metrics, not the old ones.
  - start alone does not assert out_valid.
- State convention: state s holds the previous K-1 inputs, newest at s[K-2].
  - Input u moves s to ns={u, s[K-2:1]}.
  - Predecessors of ns: p_x={ns[K-3:0], x}, x∈{0,1}.
  - Expected code bits: parity(G0 & {u,p}) and parity(G1 & {u,p}).
- Branch metric, per code bit:
  - Expected 0: r. Expected 1: (2^SOFT_W-1)-r.
  - Erased bit contributes 0.
  - BM = sum of the two bits; width SOFT_W+1.
  - Hard mode reduces to Hamming distance 0..2.
- Add: cand_x = PM[p_x]+BM. Saturates to all-ones if the true sum ≥ 2^PM_W; never wraps.
- Compare/select:
  - new PM[ns] = min(cand_0, cand_1).
  - Tie selects x=0.
  - dec_bits[ns] = selected x.
- Normalisation: if every new PM has MSB=1, clear the MSB of all of them and set norm_event=1; otherwise norm_event=0.
  - Guarantees that a non-saturated min metric never reaches all-ones.
- Timing: latency 1. Symbol accepted at edge N with in_valid=1 gives metrics, dec_bits, best_*, norm_event and out_valid=1 after edge N.
  - No back-pressure. One symbol per cycle at full rate.
  - in_valid=0: metrics hold, out_valid=0, dec_bits/best_* hold last value, norm_event=0.
- best_state/best_metric: minimum over the post-normalisation new metrics; tie picks the lowest state index. Registered together with dec_bits.
- in_erase=2'b11: BM=0 for all branches; metrics still propagate through the min-select.

Test Plan:
- Reset, then 20 symbols a0=a1=0 (K=7, hard): each cycle out_valid=1, best_state=0, best_metric=0, dec_bits[0]=0, norm_event=0.
- Encode the bit stream 1,0,1,1,0,0,0,0 with G0/G1 and flip a0 of the 3rd symbol: best_metric=1 after the error and stays 1; best_state tracks the encoder state; the dec_bits path traced back reproduces the input.
- in_erase=2'b11 for 5 symbols after reset: best_metric=0, best_state=0; no metric increases; all decisions follow the tie rule (x=0 where equal).
- PM_W=4, hard, continuous a=11 for 64 symbols versus the golden C model: norm_event pulses exactly when all metrics ≥8; no metric exceeds 15; best_metric stays ≤7 after each normalisation.
- Mid-frame start coincident with in_valid, a=00: next cycle best_metric=0, best_state=0, regardless of prior metrics.
- rst asserted mid-stream with in_valid=1: next cycle out_valid=0, best_metric=0; the first symbol after release behaves as in the first scenario.
